// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants and state encoding for the multiply/divide execute-stage sequencer.
package multdiv_ctrl_pkg;
  localparam logic [4:0]  OPC_RTYPE        = 5'b00000;
  localparam logic [4:0]  ALU_MUL          = 5'b00110;
  localparam logic [4:0]  ALU_DIV          = 5'b00111;
  localparam logic [4:0]  DEF_RSTATUS_REG  = 5'd30;
  localparam logic [31:0] DEF_MUL_EXC_CODE = 32'd4;
  localparam logic [31:0] DEF_DIV_EXC_CODE = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  function automatic logic is_md_op(input logic [31:0] ir);
    return (ir[31:27] == OPC_RTYPE) && ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
  endfunction
endpackage

// File: rtl/multdiv_ctrl_md_wait_counter.sv
// Wait-cycle counter: synchronous clear, increment on enable, flag at the last allowed cycle.
module md_wait_counter #(
  parameter int CNT_W          = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign term = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the iterative multiplier/divider: launches the op, stalls the
// front of the pipe until result or timeout, then emits one writeback packet.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          CNT_W          = 7,
  parameter logic [31:0] MUL_EXC_CODE   = DEF_MUL_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE   = DEF_DIV_EXC_CODE,
  parameter logic [4:0]  RSTATUS_REG    = DEF_RSTATUS_REG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_result_rdy,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_abort,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic        busy,
  output logic        res_valid,
  output logic [4:0]  res_reg,
  output logic [31:0] res_data
);
  md_state_e   state_q, state_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, data_q, data_d;
  logic [4:0]  rd_q, rd_d, reg_q, reg_d;
  logic        is_div_q, is_div_d;
  logic        mult_q, mult_d, div_q, div_d, abort_q, abort_d;
  logic        md_op, accept, term, finish, exc;
  logic        unused_ir;

  assign md_op     = is_md_op(dx_ir);
  assign accept    = (state_q == ST_IDLE) && md_op && !flush;
  assign finish    = (state_q == ST_WAIT) && !flush && (md_result_rdy || term);
  assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

  md_wait_counter #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == ST_START),
    .en    (state_q == ST_WAIT),
    .term  (term)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (flush) state_d = ST_IDLE;
                else if (md_result_rdy || term) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // rdy wins over timeout; a timeout with no rdy is reported as an exception
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    reg_d    = reg_q;
    data_d   = data_q;
    exc      = md_result_rdy ? md_exception : 1'b1;
    if (accept) begin
      opa_d    = dx_a;
      opb_d    = dx_b;
      rd_d     = dx_ir[26:22];
      is_div_d = (dx_ir[6:2] == ALU_DIV);
    end
    if (finish) begin
      reg_d  = exc ? RSTATUS_REG : rd_q;
      data_d = exc ? (is_div_q ? DIV_EXC_CODE : MUL_EXC_CODE) : md_result;
    end
    mult_d  = (state_q == ST_START) && !flush && !is_div_q;
    div_d   = (state_q == ST_START) && !flush &&  is_div_q;
    abort_d = flush && ((state_q == ST_START) || (state_q == ST_WAIT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      reg_q    <= '0;
      data_q   <= '0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      abort_q  <= abort_d;
    end
  end

  // stall is the only combinational output; gated so reset forces it low at once
  always_comb begin
    stall        = reset && (accept || (state_q == ST_START) || (state_q == ST_WAIT));
    busy         = (state_q != ST_IDLE);
    res_valid    = (state_q == ST_DONE);
    res_reg      = reg_q;
    res_data     = data_q;
    md_ctrl_mult = mult_q;
    md_ctrl_div  = div_q;
    md_abort     = abort_q;
    md_operand_a = opa_q;
    md_operand_b = opb_q;
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: mul/div packets, exceptions, back-to-back, flush, timeout, reset.
module tb_multdiv_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir, dx_a, dx_b, md_result;
  logic        flush, md_exception, md_result_rdy;
  logic        md_ctrl_mult, md_ctrl_div, md_abort, stall, busy, res_valid;
  logic [31:0] md_operand_a, md_operand_b, res_data;
  logic [4:0]  res_reg;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .dx_ir(dx_ir), .dx_a(dx_a), .dx_b(dx_b), .flush(flush),
    .md_result(md_result), .md_exception(md_exception), .md_result_rdy(md_result_rdy),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_abort(md_abort),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b), .stall(stall), .busy(busy),
    .res_valid(res_valid), .res_reg(res_reg), .res_data(res_data)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP = 32'h0;
  int total = 0, bad = 0, gcyc = 0;
  int n_stall, n_mult, n_div, n_abort, n_resv, busy_cyc, pulse_cyc, done_cyc, idle_cyc;
  logic [4:0]  got_reg;
  logic [31:0] got_data, got_opa, got_opb;

  function automatic logic [31:0] mk(input logic [4:0] alu, input logic [4:0] rd);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    gcyc++;
  endtask

  task automatic clr_stats();
    n_stall = 0; n_mult = 0; n_div = 0; n_abort = 0; n_resv = 0;
    busy_cyc = -1; pulse_cyc = -1; done_cyc = -1;
    got_reg = 'x; got_data = 'x; got_opa = 'x; got_opb = 'x;
  endtask

  // sample late in the cycle, after inputs for this cycle have been applied
  task automatic obs();
    #2;
    if (stall) n_stall++;
    if (md_ctrl_mult || md_ctrl_div) begin
      pulse_cyc = gcyc; got_opa = md_operand_a; got_opb = md_operand_b;
    end
    if (md_ctrl_mult) n_mult++;
    if (md_ctrl_div)  n_div++;
    if (md_abort)     n_abort++;
    if (busy && busy_cyc < 0) busy_cyc = gcyc;
    if (res_valid) begin
      n_resv++; done_cyc = gcyc; got_reg = res_reg; got_data = res_data;
    end
  endtask

  // cycle 0 = IDLE accept, 1 = START, 2.. = WAIT cycles 1..; rdy_at = WAIT cycle of rdy, 0 = never
  task automatic do_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                       input int rdy_at, input logic exc, input logic [31:0] res);
    clr_stats();
    tick();
    dx_ir = ir; dx_a = a; dx_b = b; flush = 1'b0;
    md_result_rdy = 1'b0; md_exception = 1'b0;
    obs();
    idle_cyc = gcyc;
    for (int i = 1; i < 200 && n_resv == 0; i++) begin
      tick();
      dx_a = $urandom; dx_b = $urandom;
      md_result_rdy = (rdy_at != 0) && (i == rdy_at + 1);
      md_exception  = md_result_rdy && exc;
      md_result     = md_result_rdy ? res : 32'hbad0bad0;
      obs();
    end
    md_result_rdy = 1'b0; md_exception = 1'b0; dx_ir = NOP;
    chk("op_done_seen", n_resv, 1);
  endtask

  initial begin
    reset = 1'b0; dx_ir = NOP; dx_a = 0; dx_b = 0; flush = 1'b0;
    md_result = 0; md_exception = 1'b0; md_result_rdy = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl", {26'd0, stall, busy, md_ctrl_mult, md_ctrl_div, md_abort, res_valid}, 0);
    chk("reset_res", {res_reg, res_data[26:0]} | md_operand_a | md_operand_b, 0);
    reset = 1'b1;

    // 1: mul 7*6 -> r3, rdy 16 cycles after the start pulse
    do_op(mk(5'b00110, 5'd3), 32'd7, 32'd6, 17, 1'b0, 32'd42);
    chk("t1_mult_pulses", n_mult, 1);
    chk("t1_div_pulses", n_div, 0);
    chk("t1_pulse_ofs", pulse_cyc - idle_cyc, 2);
    chk("t1_stall_cycles", n_stall, 19);
    chk("t1_res_reg", got_reg, 3);
    chk("t1_res_data", got_data, 42);
    chk("t1_operand_a", got_opa, 7);
    chk("t1_operand_b", got_opb, 6);

    // 2: div by zero, unit reports exception
    do_op(mk(5'b00111, 5'd8), 32'd100, 32'd0, 5, 1'b1, 32'd0);
    chk("t2_div_pulses", n_div, 1);
    chk("t2_mult_pulses", n_mult, 0);
    chk("t2_res_reg", got_reg, 30);
    chk("t2_res_data", got_data, 5);

    // 3: mul then div back to back
    do_op(mk(5'b00110, 5'd7), 32'd5, 32'd9, 3, 1'b0, 32'd45);
    chk("t3a_res_reg", got_reg, 7);
    chk("t3a_res_data", got_data, 45);
    begin
      int first_done;
      first_done = done_cyc;
      do_op(mk(5'b00111, 5'd9), 32'd100, 32'd7, 4, 1'b0, 32'd14);
      chk("t3_start_gap", busy_cyc - first_done, 2);
    end
    chk("t3b_div_pulses", n_div, 1);
    chk("t3b_operand_a", got_opa, 100);
    chk("t3b_operand_b", got_opb, 7);
    chk("t3b_res_reg", got_reg, 9);
    chk("t3b_res_data", got_data, 14);

    // 4: flush in WAIT cycle 5, stray rdy two cycles later
    clr_stats();
    tick();
    dx_ir = mk(5'b00110, 5'd2); dx_a = 32'd11; dx_b = 32'd12;
    obs();
    for (int i = 1; i <= 6; i++) begin
      tick();
      flush = (i == 6);
      obs();
    end
    tick();
    flush = 1'b0; dx_ir = NOP;
    obs();
    chk("t4_abort_now", md_abort, 1);
    chk("t4_stall_after", stall, 0);
    chk("t4_busy_after", busy, 0);
    for (int i = 8; i <= 14; i++) begin
      tick();
      md_result_rdy = (i == 8); md_result = 32'd77;
      obs();
    end
    md_result_rdy = 1'b0;
    chk("t4_abort_count", n_abort, 1);
    chk("t4_no_res_valid", n_resv, 0);
    chk("t4_idle", busy, 0);

    // 5: mul that never completes -> timeout after 64 WAIT cycles
    do_op(mk(5'b00110, 5'd5), 32'd2, 32'd3, 0, 1'b0, 32'd0);
    chk("t5_done_ofs", done_cyc - idle_cyc, 66);
    chk("t5_stall_cycles", n_stall, 66);
    chk("t5_res_reg", got_reg, 30);
    chk("t5_res_data", got_data, 4);

    // 6: async reset mid-WAIT, then a fresh mul
    clr_stats();
    tick();
    dx_ir = mk(5'b00110, 5'd6); dx_a = 32'd21; dx_b = 32'd22;
    obs();
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs();
    end
    #1 reset = 1'b0;
    #1;
    chk("t6_async_ctl", {26'd0, stall, busy, md_ctrl_mult, md_ctrl_div, md_abort, res_valid}, 0);
    chk("t6_async_opa", md_operand_a, 0);
    chk("t6_async_opb", md_operand_b, 0);
    chk("t6_async_res", {27'd0, res_reg} | res_data, 0);
    tick();
    dx_ir = NOP;
    tick();
    reset = 1'b1;
    clr_stats();
    tick();
    md_result_rdy = 1'b1; md_result = 32'd1234;
    obs();
    tick();
    md_result_rdy = 1'b0;
    obs();
    tick();
    obs();
    chk("t6_stale_rdy_ignored", n_resv, 0);
    chk("t6_stale_idle", busy, 0);
    do_op(mk(5'b00110, 5'd4), 32'd3, 32'd3, 2, 1'b0, 32'd9);
    chk("t6_res_reg", got_reg, 4);
    chk("t6_res_data", got_data, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
